// File: rtl/arith_pkg.sv
// arith_pkg: shared slice width, subtractor FSM states and zero-detect helper
package arith_pkg;
    localparam int SLICE_W = 4;
    localparam int MAX_W = 256;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    function automatic logic is_zero(input logic [MAX_W-1:0] v);
        return v == '0;
    endfunction
endpackage

// File: rtl/sub4_bla.sv
// sub4_bla: combinational 4-bit borrow-lookahead subtract slice, d = a - b - borrow_in
module sub4_bla (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       borrow_in,
    output logic [3:0] d,
    output logic       borrow_out
);
    logic [3:0] w_p, w_g;
    logic [4:0] w_c;
    // Subtraction is a + ~b + 1, so the carry chain runs with carry = ~borrow
    assign w_p = a ^ ~b;
    assign w_g = a & ~b;
    assign w_c[0] = ~borrow_in;
    assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign d = w_p ^ w_c[3:0];
    assign borrow_out = ~w_c[4];
endmodule

// File: rtl/seq_sub_bla.sv
// seq_sub_bla: multi-cycle unsigned subtractor, one 4-bit borrow-lookahead slice per clock
module seq_sub_bla
    import arith_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);
    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int KW = NSLICE > 1 ? $clog2(NSLICE) : 1;

    if (WIDTH % SLICE_W != 0 || WIDTH < SLICE_W || WIDTH > MAX_W) begin : g_bad_width
        $error("seq_sub_bla: WIDTH must be a multiple of 4 in [4, 256]");
    end

    state_t           r_state;
    logic [KW-1:0]    r_k;
    logic [WIDTH-1:0] r_a, r_b, r_diff;
    logic             r_borrow, r_bout, r_zero;
    logic [3:0]       w_d;
    logic             w_bo, w_last;
    logic [WIDTH-1:0] w_diff_nx;

    sub4_bla u_slice (
        .a         (r_a[r_k*SLICE_W +: SLICE_W]),
        .b         (r_b[r_k*SLICE_W +: SLICE_W]),
        .borrow_in (r_borrow),
        .d         (w_d),
        .borrow_out(w_bo)
    );

    assign w_last = r_k == KW'(NSLICE - 1);

    always_comb begin
        w_diff_nx = r_diff;
        w_diff_nx[r_k*SLICE_W +: SLICE_W] = w_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_k      <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_borrow <= 1'b0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_a      <= a;
                    r_b      <= b;
                    r_borrow <= bin;
                    r_k      <= '0;
                    r_state  <= RUN;
                end
                RUN: begin
                    r_diff   <= w_diff_nx;
                    r_borrow <= w_bo;
                    if (w_last) begin
                        r_bout  <= w_bo;
                        r_zero  <= is_zero(MAX_W'(w_diff_nx));
                        r_state <= DONE;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                DONE: if (out_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_state == IDLE;
    assign out_valid = r_state == DONE;
    assign diff      = r_diff;
    assign bout      = r_bout;
    assign zero      = r_zero;
endmodule

// File: tb/tb_seq_sub_bla.sv
// tb_seq_sub_bla: directed and randomized checks of seq_sub_bla against an arithmetic model
module tb_seq_sub_bla;
    parameter int WIDTH = 16;
    localparam int NSLICE = WIDTH / 4;
    localparam int NRAND = 1000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             bin = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;

    int n_checks = 0;
    int n_errors = 0;

    seq_sub_bla #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic c);
        return {1'b0, x} - {1'b0, y} - (WIDTH + 1)'(c);
    endfunction

    function automatic logic [WIDTH-1:0] rnd();
        return WIDTH'({$urandom(), $urandom()});
    endfunction

    task automatic check_result(input string tag, input logic [WIDTH:0] e);
        check({tag, "_diff"}, 64'(diff), 64'(e[WIDTH-1:0]));
        check({tag, "_bout"}, 64'(bout), 64'(e[WIDTH]));
        check({tag, "_zero"}, 64'(zero), 64'(e[WIDTH-1:0] == '0));
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic c, output logic [WIDTH:0] e);
        int cnt;
        e = model(x, y, c);
        a = x; b = y; bin = c; in_valid = 1'b1;
        check({tag, "_rdy"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0; a = rnd(); b = rnd(); bin = ~c;
        cnt = 0;
        while (!out_valid && cnt < 64) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, "_lat"}, 64'(cnt), 64'(NSLICE));
        check_result(tag, e);
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_ovdrop"}, 64'(out_valid), 64'd0);
        check({tag, "_idle"}, 64'(in_ready), 64'd1);
    endtask

    logic [WIDTH:0] exp_q[$];
    logic [WIDTH:0] e, f;
    int n_acc, n_res, cyc;

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_diff", 64'(diff), 64'd0);
        check("rst_bout", 64'(bout), 64'd0);
        check("rst_zero", 64'(zero), 64'd0);
        check("rst_ov", 64'(out_valid), 64'd0);
        check("rst_ir", 64'(in_ready), 64'd1);

        run_op("t1", WIDTH'(16'h1234), WIDTH'(16'h0234), 1'b0, e); consume("t1");
        run_op("t2a", WIDTH'(16'h0000), WIDTH'(16'h0001), 1'b0, e); consume("t2a");
        run_op("t2b", WIDTH'(16'h0100), WIDTH'(16'h0001), 1'b0, e); consume("t2b");
        run_op("t3a", WIDTH'(16'h8000), WIDTH'(16'h7FFF), 1'b1, e); consume("t3a");
        run_op("t3b", WIDTH'(16'h0005), WIDTH'(16'h0005), 1'b1, e); consume("t3b");

        // Backpressure: result must hold while new operands are offered and ignored
        run_op("bp", WIDTH'(16'hA5C3), WIDTH'(16'h3C5A), 1'b0, e);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; a = rnd(); b = rnd(); bin = 1'(i);
            @(negedge clk);
            check("bp_hold", 64'(out_valid), 64'd1);
            check("bp_irdy", 64'(in_ready), 64'd0);
            check_result("bp_stable", e);
        end
        a = WIDTH'(16'h00F0); b = WIDTH'(16'h0F00); bin = 1'b1;
        consume("bp");
        run_op("bp_next", WIDTH'(16'h00F0), WIDTH'(16'h0F00), 1'b1, e); consume("bp_next");

        // Abort mid-run after two slices
        a = WIDTH'(16'h7777); b = WIDTH'(16'h1111); bin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_diff", 64'(diff), 64'd0);
        check("abort_ov", 64'(out_valid), 64'd0);
        check("abort_ir", 64'(in_ready), 64'd1);
        check("abort_bout", 64'(bout), 64'd0);
        check("abort_zero", 64'(zero), 64'd0);
        run_op("post_abort", WIDTH'(16'hFFFF), WIDTH'(16'h0001), 1'b0, e); consume("post_abort");

        // Random traffic with random gaps and output stalls
        n_acc = 0; n_res = 0; cyc = 0;
        while (n_res < NRAND && cyc < NRAND * 40) begin
            in_valid = (n_acc < NRAND) && ($urandom_range(0, 3) != 0);
            a = rnd();
            b = ($urandom_range(0, 7) == 0) ? a : rnd();
            bin = 1'($urandom_range(0, 1));
            out_ready = $urandom_range(0, 2) != 0;
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, bin));
                n_acc++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rnd_spurious", 64'(out_valid), 64'd0);
                end else begin
                    f = exp_q.pop_front();
                    check_result("rnd", f);
                end
                n_res++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("rnd_count", 64'(n_res), 64'(NRAND));
        check("rnd_acc_eq_res", 64'(n_acc), 64'(n_res));
        check("rnd_q_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/seq_sub_bla.md
Name: seq_sub_bla

Overview:
Multi-cycle unsigned subtractor, the inverse-direction companion to the team's 4-bit carry-lookahead adder. Computes diff = a - b - bin over WIDTH/4 clock cycles, one 4-bit borrow-lookahead slice per cycle. Uses a valid/ready handshake on both input and output. Sits in the arithmetic datapath wherever area matters more than single-cycle latency.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4 (elaboration-time check fails otherwise).
NSLICE, WIDTH/4, derived; number of slice cycles; not user-overridable.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operands valid.
in_ready  output  1  block can accept operands (high only in IDLE).
a  input  WIDTH  minuend (unsigned).
b  input  WIDTH  subtrahend (unsigned).
bin  input  1  borrow-in.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts result.
diff  output  WIDTH  a - b - bin, modulo 2^WIDTH.
bout  output  1  borrow-out; 1 iff a < b + bin (unsigned).
zero  output  1  1 iff diff == 0.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset: state=IDLE, slice counter=0, diff=0, bout=0, zero=0, out_valid=0, in_ready=1. Operand and borrow registers are cleared.
- FSM states are IDLE, RUN and DONE. in_ready = (state==IDLE); out_valid = (state==DONE).
- IDLE:
  - On an edge with in_valid=1, latch a, b and bin into internal registers, set the borrow register to bin, set k=0, and go to RUN.
  - Otherwise remain in IDLE.
- RUN, on each edge:
  - Slice k uses a[4k+3:4k] and ~b[4k+3:4k] with carry-in c0 = ~borrow.
  - Per bit: p = a ^ ~b, g = a & ~b.
  - Lookahead carries: c1 = g0|p0c0; c2 = g1|p1g0|p1p0c0; c3 = similarly; c4 = the full 4-term expansion.
  - diff[4k+i] <= p_i ^ c_i, and borrow <= ~c4.
  - If k==NSLICE-1, go to DONE; otherwise k <= k+1.
- Entering DONE:
  - bout <= final borrow.
  - zero <= (complete diff == 0), evaluated on the final diff value including the last slice.
- DONE: hold diff, bout and zero stable. On an edge with out_ready=1, go to IDLE. out_valid falls on that edge.
- Latency and throughput:
  - The acceptance edge is E0. out_valid=1 after edge E(NSLICE), i.e. 4 edges for WIDTH=16.
  - Minimum issue interval is NSLICE+2 cycles, because there is no accept in the same cycle a result is consumed.
- in_valid while not in IDLE is ignored, and no operand registers change.
- Changes on the a, b and bin pins after acceptance have no effect.
- diff is registered and may show partial slices during RUN. It is only meaningful while out_valid=1.
- Reset asserted in any state, including mid-RUN or DONE with out_ready=0, aborts the operation. Next cycle all outputs take their reset values and no result is emitted.
- Wrap-around: results are modulo 2^WIDTH; bout carries the sign information. No overflow flag.

Decomposition:
- Shared package (arith_pkg):
  - SLICE_W = 4.
  - FSM state enum {IDLE, RUN, DONE}.
  - Helper function for the zero reduction.
- Sub-module sub4_bla: combinational 4-bit borrow-lookahead slice.
  - Inputs: a[3:0], b[3:0], borrow_in.
  - Outputs: d[3:0], borrow_out.
  - The top level instantiates it once and time-multiplexes it across slices.

Test Plan:
1. WIDTH=16: a=0x1234, b=0x0234, bin=0 -> out_valid 4 edges after accept; diff=0x1000, bout=0, zero=0.
2. a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, zero=0. Also a=0x0100, b=0x0001 -> diff=0x00FF, exercising borrow across slice boundaries.
3. a=0x8000, b=0x7FFF, bin=1 -> diff=0x0000, zero=1, bout=0. Also a=0x0005, b=0x0005, bin=1 -> diff=0xFFFF, bout=1.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid, pulse in_valid with new operands, and toggle the a/b pins -> diff, bout and zero stay stable, in_ready=0, and the new operands are not captured. Raising out_ready -> IDLE next edge, then the new op is accepted.
5. Reset mid-RUN after 2 slices -> next cycle diff=0, out_valid=0, in_ready=1, state IDLE. The following op a=0xFFFF, b=0x0001 -> diff=0xFFFE, bout=0.
6. 1000 random back-to-back ops with random out_ready stalls (including WIDTH=4 and WIDTH=32 builds) -> every result matches the golden model {bout,diff} = {1'b0,a} - b - bin, and the result count equals the accept count.
